cook_sequencer: RTL and testbench

- Top-level cook-cycle controller for the microwave. It owns the MM:SS BCD countdown and the power-level duty cycling of the magnetron.
- Sequences the cook cycle across five phases: load, cook, pause, finish, beep.
- Its magnetron_on output drives the magnetron control path; start/stop/clear/door inputs come from the debounced keypad and door-switch logic.

---
 rtl/cook_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cook_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - microwave cook-cycle controller: BCD countdown, power duty cycling, door interlock
// Optional end-of-cook beeper enabled by defining COOK_BEEP_EN.
module cook_sequencer #(
   parameter int BEEP_TICKS  = 3,
   parameter int DUTY_WINDOW = 10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        tick_1hz,
   input  logic        startn,
   input  logic        stopn,
   input  logic        clearn,
   input  logic        door_closed,
   input  logic        load,
   input  logic [15:0] time_in,
   input  logic [3:0]  power_level,
   output logic        magnetron_on,
   output logic [15:0] time_left,
   output logic [2:0]  state,
   output logic        beep
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMED  = 3'd1,
      S_COOK   = 3'd2,
      S_PAUSED = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t      cur, nxt;
   logic [15:0] time_nx;
   logic [7:0]  duty, duty_nx, duty_inc;
   logic        on_reg, on_nx;
   logic        startn_q;
   logic        start_evt;
   logic [15:0] load_val;
   logic [3:0]  eff_power;

   // Seconds above 5x saturate the whole seconds field; any other non-BCD digit saturates to 9.
   function automatic logic [15:0] clamp_time(input logic [15:0] t);
      logic [3:0] m1, m0, s1, s0;
      m1 = (t[15:12] > 4'd9) ? 4'd9 : t[15:12];
      m0 = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
      if (t[7:4] > 4'd5) begin
         s1 = 4'd5;
         s0 = 4'd9;
      end else begin
         s1 = t[7:4];
         s0 = (t[3:0] > 4'd9) ? 4'd9 : t[3:0];
      end
      return {m1, m0, s1, s0};
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [15:0] r;
      r = t;
      if (t[3:0] != 4'd0) begin
         r[3:0] = t[3:0] - 4'd1;
      end else if (t[7:4] != 4'd0) begin
         r[7:4] = t[7:4] - 4'd1;
         r[3:0] = 4'd9;
      end else begin
         r[7:0] = 8'h59;
         if (t[11:8] != 4'd0) begin
            r[11:8] = t[11:8] - 4'd1;
         end else begin
            r[15:12] = t[15:12] - 4'd1;
            r[11:8]  = 4'd9;
         end
      end
      return r;
   endfunction

   assign start_evt = startn_q & ~startn;
   assign load_val  = clamp_time(time_in);
   assign eff_power = (power_level == 4'd0 || power_level > 4'd10) ? 4'd10 : power_level;
   assign duty_inc  = (duty == 8'(DUTY_WINDOW - 1)) ? 8'd0 : duty + 8'd1;

`ifdef COOK_BEEP_EN
   logic       beep_r, beep_nx;
   logic [7:0] bcnt, bcnt_nx;
   assign beep = beep_r;
`else
   assign beep = 1'b0;
`endif

   always_comb begin
      nxt     = cur;
      time_nx = time_left;
      duty_nx = duty;
`ifdef COOK_BEEP_EN
      beep_nx = beep_r;
      bcnt_nx = bcnt;
`endif
      case (cur)
         S_IDLE: begin
            if (!clearn) begin
               time_nx = 16'h0000;
            end else if (load) begin
               time_nx = load_val;
               nxt     = (load_val != 16'h0000) ? S_ARMED : S_IDLE;
            end
         end
         S_ARMED: begin
            if (!clearn) begin
               nxt     = S_IDLE;
               time_nx = 16'h0000;
            end else if (start_evt && door_closed) begin
               nxt     = S_COOK;
               duty_nx = 8'd0;
            end else if (load) begin
               time_nx = load_val;
               nxt     = (load_val != 16'h0000) ? S_ARMED : S_IDLE;
            end
         end
         S_COOK: begin
            if (!door_closed) begin
               nxt = S_PAUSED;
            end else if (!clearn) begin
               nxt     = S_IDLE;
               time_nx = 16'h0000;
            end else if (!stopn) begin
               nxt = S_PAUSED;
            end else if (tick_1hz) begin
               time_nx = bcd_dec(time_left);
               duty_nx = duty_inc;
               if (time_left == 16'h0001) begin
                  nxt = S_DONE;
`ifdef COOK_BEEP_EN
                  beep_nx = 1'b1;
                  bcnt_nx = 8'd0;
`endif
               end
            end
         end
         S_PAUSED: begin
            if (!clearn || !stopn) begin
               nxt     = S_IDLE;
               time_nx = 16'h0000;
            end else if (start_evt && door_closed) begin
               nxt = S_COOK;
            end else if (load) begin
               time_nx = load_val;
               nxt     = (load_val != 16'h0000) ? S_ARMED : S_IDLE;
            end
         end
         S_DONE: begin
`ifdef COOK_BEEP_EN
            if (!door_closed || !clearn || !stopn) begin
               nxt     = S_IDLE;
               beep_nx = 1'b0;
            end else if (tick_1hz) begin
               if (bcnt == 8'(BEEP_TICKS - 1)) begin
                  nxt     = S_IDLE;
                  beep_nx = 1'b0;
               end else begin
                  bcnt_nx = bcnt + 8'd1;
               end
            end
`else
            nxt = S_IDLE;
`endif
         end
         default: nxt = S_IDLE;
      endcase
      on_nx = (nxt == S_COOK) && (duty_nx < {4'd0, eff_power});
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cur       <= S_IDLE;
         time_left <= 16'h0000;
         duty      <= 8'd0;
         on_reg    <= 1'b0;
         startn_q  <= 1'b1;
`ifdef COOK_BEEP_EN
         beep_r    <= 1'b0;
         bcnt      <= 8'd0;
`endif
      end else begin
         cur       <= nxt;
         time_left <= time_nx;
         duty      <= duty_nx;
         on_reg    <= on_nx;
         startn_q  <= startn;
`ifdef COOK_BEEP_EN
         beep_r    <= beep_nx;
         bcnt      <= bcnt_nx;
`endif
      end
   end

   // Door gating stays combinational so an opening door cuts the magnetron immediately.
   assign magnetron_on = on_reg & door_closed;
   assign state        = cur;

endmodule

// File: tb/tb_cook_sequencer.sv
// tb/tb_cook_sequencer.sv - scoreboard bench for cook_sequencer
module tb_cook_sequencer;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        tick_1hz = 1'b0;
   logic        startn = 1'b1;
   logic        stopn = 1'b1;
   logic        clearn = 1'b1;
   logic        door_closed = 1'b1;
   logic        load = 1'b0;
   logic [15:0] time_in = 16'h0000;
   logic [3:0]  power_level = 4'd10;
   logic        magnetron_on;
   logic [15:0] time_left;
   logic [2:0]  state;
   logic        beep;

   localparam int IDLE = 0, ARMED = 1, COOK = 2, PAUSED = 3, DONE = 4;

   cook_sequencer #(.BEEP_TICKS(3), .DUTY_WINDOW(10)) dut (
      .clk(clk), .resetn(resetn), .tick_1hz(tick_1hz), .startn(startn), .stopn(stopn),
      .clearn(clearn), .door_closed(door_closed), .load(load), .time_in(time_in),
      .power_level(power_level), .magnetron_on(magnetron_on), .time_left(time_left),
      .state(state), .beep(beep)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int secs = 0;
   string       sb_tag[$];
   int          sb_kind[$];
   logic [15:0] sb_val[$];

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic want(input string tag, input int kind, input logic [15:0] v);
      sb_tag.push_back(tag);
      sb_kind.push_back(kind);
      sb_val.push_back(v);
   endtask

   task automatic want_all(input string tag, input int st, input logic [15:0] tl, input logic mg);
      want({tag, ".state"}, 0, 16'(st));
      want({tag, ".time"}, 1, tl);
      want({tag, ".mag"}, 2, {15'd0, mg});
   endtask

   task automatic score();
      string tg;
      int k;
      logic [15:0] v, got;
      while (sb_tag.size() != 0) begin
         tg = sb_tag.pop_front();
         k  = sb_kind.pop_front();
         v  = sb_val.pop_front();
         case (k)
            0:       got = {13'd0, state};
            1:       got = time_left;
            2:       got = {15'd0, magnetron_on};
            default: got = {15'd0, beep};
         endcase
         chk(tg, got, v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      step();
      score();
   endtask

   task automatic do_load(input string tag, input logic [15:0] v, input int st);
      load = 1'b1;
      time_in = v;
      want_all(tag, st, to_bcd(secs), 1'b0);
      cyc();
      load = 1'b0;
   endtask

   task automatic do_start(input string tag, input logic mg);
      startn = 1'b0;
      want_all(tag, COOK, to_bcd(secs), mg);
      cyc();
      startn = 1'b1;
      step();
   endtask

   task automatic do_tick(input string tag, input logic mg);
      secs--;
      tick_1hz = 1'b1;
      want_all(tag, (secs == 0) ? DONE : COOK, to_bcd(secs), (secs == 0) ? 1'b0 : mg);
      cyc();
      tick_1hz = 1'b0;
   endtask

   task automatic finish_done(input string tag);
`ifdef COOK_BEEP_EN
      want({tag, ".beep_on"}, 3, 16'd1);
      score();
      for (int k = 1; k <= 3; k++) begin
         tick_1hz = 1'b1;
         want($sformatf("%s.bt%0d.state", tag, k), 0, 16'((k < 3) ? DONE : IDLE));
         want($sformatf("%s.bt%0d.beep", tag, k), 3, 16'((k < 3) ? 1 : 0));
         cyc();
         tick_1hz = 1'b0;
      end
`else
      want({tag, ".beep"}, 3, 16'd0);
      want_all(tag, IDLE, 16'h0000, 1'b0);
      cyc();
`endif
   endtask

   initial begin
      resetn = 1'b0;
      step();
      step();
      want_all("rst", IDLE, 16'h0000, 1'b0);
      want("rst.beep", 3, 16'd0);
      score();
      resetn = 1'b1;
      step();

      startn = 1'b0;
      want_all("idle_start", IDLE, 16'h0000, 1'b0);
      cyc();
      startn = 1'b1;
      step();

      // basic 12 s cook at full power
      power_level = 4'd10;
      secs = 12;
      do_load("ld0012", 16'h0012, ARMED);
      do_start("st0012", 1'b1);
      for (int i = 0; i < 12; i++) do_tick($sformatf("b%0d", i), 1'b1);
      finish_done("done0012");

      // minute borrow then full run out
      secs = 60;
      do_load("ld0100", 16'h0100, ARMED);
      do_start("st0100", 1'b1);
      for (int i = 0; i < 60; i++) do_tick($sformatf("m%0d", i), 1'b1);
      finish_done("done0100");

      secs = 59;
      do_load("ld0075", 16'h0075, ARMED);
      secs = 99 * 60 + 59;
      do_load("ld9AF3", 16'h9AF3, ARMED);
      secs = 0;
      do_load("ld0000", 16'h0000, IDLE);

      // power 3 duty window
      power_level = 4'd3;
      secs = 10;
      do_load("ld_p3", 16'h0010, ARMED);
      do_start("st_p3", 1'b1);
      for (int i = 1; i <= 10; i++) do_tick($sformatf("p3_%0d", i), (i < 3));
      finish_done("done_p3");

      power_level = 4'd0;
      secs = 5;
      do_load("ld_p0", 16'h0005, ARMED);
      do_start("st_p0", 1'b1);
      for (int i = 1; i <= 3; i++) do_tick($sformatf("p0_%0d", i), 1'b1);
      clearn = 1'b0;
      want_all("clr_cook", IDLE, 16'h0000, 1'b0);
      cyc();
      clearn = 1'b1;

      // door interlock at 00:30
      power_level = 4'd10;
      secs = 40;
      do_load("ld0040", 16'h0040, ARMED);
      do_start("st0040", 1'b1);
      for (int i = 0; i < 10; i++) do_tick($sformatf("d%0d", i), 1'b1);
      door_closed = 1'b0;
      want("door_comb.mag", 2, 16'd0);
      #1;
      score();
      want_all("door_pause", PAUSED, 16'h0030, 1'b0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         tick_1hz = 1'b1;
         want_all($sformatf("door_hold%0d", i), PAUSED, 16'h0030, 1'b0);
         cyc();
         tick_1hz = 1'b0;
      end
      door_closed = 1'b1;
      do_start("resume", 1'b1);
      do_tick("resume_tick", 1'b1);

      stopn = 1'b0;
      want_all("stop1", PAUSED, to_bcd(secs), 1'b0);
      cyc();
      stopn = 1'b1;
      step();
      stopn = 1'b0;
      want_all("stop2", IDLE, 16'h0000, 1'b0);
      cyc();
      stopn = 1'b1;

      secs = 20;
      do_load("ld_clr", 16'h0020, ARMED);
      clearn = 1'b0;
      want_all("clr_arm", IDLE, 16'h0000, 1'b0);
      cyc();
      clearn = 1'b1;

      // startn held low: only the first edge counts
      secs = 20;
      do_load("ld_hold", 16'h0020, ARMED);
      startn = 1'b0;
      want_all("hold_start", COOK, 16'h0020, 1'b1);
      cyc();
      step();
      stopn = 1'b0;
      want_all("hold_stop", PAUSED, 16'h0020, 1'b0);
      cyc();
      stopn = 1'b1;
      for (int i = 0; i < 17; i++) begin
         want_all($sformatf("hold%0d", i), PAUSED, 16'h0020, 1'b0);
         cyc();
      end
      startn = 1'b1;
      step();

      startn = 1'b0;
      tick_1hz = 1'b1;
      want_all("tick_start", COOK, 16'h0020, 1'b1);
      cyc();
      startn = 1'b1;
      tick_1hz = 1'b0;
      step();
      tick_1hz = 1'b1;
      stopn = 1'b0;
      want_all("tick_stop", PAUSED, 16'h0020, 1'b0);
      cyc();
      tick_1hz = 1'b0;
      stopn = 1'b1;
      step();

      // reset mid-cook
      do_start("rst_st", 1'b1);
      do_tick("rst_tick", 1'b1);
      resetn = 1'b0;
      want_all("rst_mid", IDLE, 16'h0000, 1'b0);
      want("rst_mid.beep", 3, 16'd0);
      cyc();
      resetn = 1'b1;
      want_all("post_rst", IDLE, 16'h0000, 1'b0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
